// File: rtl/matrix_pkg.sv
// Shared types and constants for the LED matrix pattern scheduler.
package matrix_pkg;

    localparam int NUM_PTN_DEFAULT = 7;

    // Bit positions inside the mode switch word; bits [2:0] are the manual index.
    localparam int MODE_W      = 6;
    localparam int MODE_AUTO   = 3;
    localparam int MODE_SCROLL = 4;
    localparam int MODE_HOLD   = 5;

    localparam logic [3:0] ROW_LAST = 4'd15;

    typedef enum logic [1:0] {
        S_BLANK,
        S_MANUAL,
        S_AUTO,
        S_HOLD
    } state_e;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matrix_ptn_scheduler_sw_sync.sv
// Parameterized-width two-flop synchronizer for asynchronous switch inputs.
module sw_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // NOTE: both stages take the async reset so no stale switch value survives reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/matrix_ptn_scheduler.sv
// Frame-synchronous sequencer for the 16x16 LED matrix: pattern index, blank and scroll offset.
module matrix_ptn_scheduler
    import matrix_pkg::*;
#(
    parameter int NUM_PTN       = NUM_PTN_DEFAULT,
    parameter int DWELL_FRAMES  = 64,
    parameter int SCROLL_FRAMES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       row_tick,
    input  logic [3:0] row_bin,
    input  logic [5:0] mode,
    output logic [2:0] ptn_idx,
    output logic       blank,
    output logic [3:0] scroll_ofs,
    output logic       frame_start
);

    localparam int DW = cnt_width(DWELL_FRAMES);
    localparam int SW = cnt_width(SCROLL_FRAMES);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_FRAMES - 1);
    localparam logic [SW-1:0] SCR_LAST   = SW'(SCROLL_FRAMES - 1);
    localparam logic [2:0]    PTN_LAST   = 3'(NUM_PTN - 1);
    localparam logic [3:0]    PTN_COUNT  = 4'(NUM_PTN);

    logic [MODE_W-1:0] mode_sync;
    logic [MODE_W-1:0] shadow_q;
    logic              fb;
    logic              upd_q;
    logic              frame_start_q;

    state_e state_q, state_d, resume_q, prev_run;

    logic [2:0]    ptn_q, ptn_d;
    logic          blank_q, blank_d;
    logic [3:0]    ofs_q, ofs_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [SW-1:0] scr_q, scr_d;

    sw_sync #(.WIDTH(MODE_W)) u_sw_sync (
        .clk  (clk),
        .rst_n(rst),
        .d_i  (mode),
        .q_o  (mode_sync)
    );

    assign fb = row_tick && (row_bin == ROW_LAST);

    // Switches are latched at the frame boundary and acted on one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_q      <= '0;
            upd_q         <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            upd_q         <= fb;
            frame_start_q <= upd_q;
            if (fb) shadow_q <= mode_sync;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_BLANK;
            resume_q <= S_BLANK;
        end else begin
            state_q <= state_d;
            if (state_q != S_HOLD) resume_q <= state_q;
        end
    end

    always_comb begin
        state_d = state_q;
        if (upd_q) begin
            if (shadow_q[MODE_HOLD])      state_d = S_HOLD;
            else if (shadow_q[MODE_AUTO]) state_d = S_AUTO;
            else                          state_d = S_MANUAL;
        end
    end

    // Leaving hold resumes whatever ran before it, so auto entry is judged against that.
    assign prev_run = (state_q == S_HOLD) ? resume_q : state_q;

    always_comb begin
        // NOTE: every next-state value defaults to its register so no latch is inferred.
        ptn_d   = ptn_q;
        blank_d = blank_q;
        ofs_d   = ofs_q;
        dwell_d = dwell_q;
        scr_d   = scr_q;
        if (upd_q && (state_d != S_HOLD)) begin
            if (state_d == S_AUTO) begin
                blank_d = 1'b0;
                if (prev_run != S_AUTO) begin
                    ptn_d   = 3'd0;
                    dwell_d = '0;
                end else if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    ptn_d   = (ptn_q == PTN_LAST) ? 3'd0 : ptn_q + 3'd1;
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end else begin
                dwell_d = '0;
                if ({1'b0, shadow_q[2:0]} < PTN_COUNT) begin
                    ptn_d   = shadow_q[2:0];
                    blank_d = 1'b0;
                end else begin
                    blank_d = 1'b1;
                end
            end

            if (shadow_q[MODE_SCROLL]) begin
                if (scr_q == SCR_LAST) begin
                    scr_d = '0;
                    ofs_d = ofs_q + 4'd1;
                end else begin
                    scr_d = scr_q + SW'(1);
                end
            end else begin
                scr_d = '0;
                ofs_d = 4'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptn_q   <= 3'd0;
            blank_q <= 1'b1;
            ofs_q   <= 4'd0;
            dwell_q <= '0;
            scr_q   <= '0;
        end else begin
            ptn_q   <= ptn_d;
            blank_q <= blank_d;
            ofs_q   <= ofs_d;
            dwell_q <= dwell_d;
            scr_q   <= scr_d;
        end
    end

    assign ptn_idx     = ptn_q;
    assign blank       = blank_q;
    assign scroll_ofs  = ofs_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_matrix_ptn_scheduler.sv
// Self-checking bench: directed scenarios plus randomized mode traffic against a frame-level model.
module tb_matrix_ptn_scheduler;

    localparam int NUM_PTN = 7;
    localparam int DWELL   = 4;
    localparam int SCROLL  = 2;

    logic       clk;
    logic       rst;
    logic       row_tick;
    logic [3:0] row_bin;
    logic [5:0] mode;
    logic [2:0] ptn_idx;
    logic       blank;
    logic [3:0] scroll_ofs;
    logic       frame_start;

    matrix_ptn_scheduler #(
        .NUM_PTN      (NUM_PTN),
        .DWELL_FRAMES (DWELL),
        .SCROLL_FRAMES(SCROLL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .row_tick   (row_tick),
        .row_bin    (row_bin),
        .mode       (mode),
        .ptn_idx    (ptn_idx),
        .blank      (blank),
        .scroll_ofs (scroll_ofs),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Frame-level reference: patterns and offsets derived from frame counts.
    int last_run;       // 0 = none since reset, 1 = manual, 2 = auto
    int auto_n;         // frames since auto was entered
    int scroll_n;       // frames counted with scroll enabled
    int m_ptn;
    int m_blank;
    int m_ofs;

    int         gcyc   = -1;
    int         fb_age = -1;
    logic [5:0] fb_mode;
    logic [5:0] r1, r2;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        last_run = 0;
        auto_n   = 0;
        scroll_n = 0;
        m_ptn    = 0;
        m_blank  = 1;
        m_ofs    = 0;
    endtask

    task automatic model_fb(input logic [5:0] m);
        if (!m[5]) begin
            if (m[3]) begin
                auto_n   = (last_run == 2) ? auto_n + 1 : 0;
                m_ptn    = (auto_n / DWELL) % NUM_PTN;
                m_blank  = 0;
                last_run = 2;
            end else begin
                if (int'(m[2:0]) < NUM_PTN) begin
                    m_ptn   = int'(m[2:0]);
                    m_blank = 0;
                end else begin
                    m_blank = 1;
                end
                last_run = 1;
            end
            if (m[4]) begin
                scroll_n = scroll_n + 1;
                m_ofs    = (scroll_n / SCROLL) % 16;
            end else begin
                scroll_n = 0;
                m_ofs    = 0;
            end
        end
    endtask

    // One clock: compare outputs after the last rising edge, then drive the row scanner.
    task automatic step();
        int exp_fs;
        @(negedge clk);
        if (fb_age >= 0) fb_age++;
        exp_fs = 0;
        if (fb_age == 2) begin
            model_fb(fb_mode);
            exp_fs = 1;
            fb_age = -1;
        end
        check("frame_start", 32'(frame_start), 32'(exp_fs));
        check("ptn_idx", 32'(ptn_idx), 32'(m_ptn));
        check("blank", 32'(blank), 32'(m_blank));
        check("scroll_ofs", 32'(scroll_ofs), 32'(m_ofs));
        gcyc++;
        row_tick = (gcyc % 4 == 0);
        row_bin  = 4'((gcyc / 4) % 16);
        if (row_tick && row_bin == 4'd15 && rst) begin
            fb_age  = 0;
            fb_mode = mode;
        end
    endtask

    // One 64-cycle frame ending just after its settings become visible.
    task automatic frame(input logic [5:0] m1, input int at1, input logic [5:0] m2,
                         input int at2, input int rst_at);
        for (int j = 0; j < 64; j++) begin
            if (j == at1) mode = m1;
            if (j == at2) mode = m2;
            if (j == rst_at) begin
                #2 rst = 1'b0;
                #1;
                check("arst_ptn", 32'(ptn_idx), 32'd0);
                check("arst_blank", 32'(blank), 32'd1);
                check("arst_ofs", 32'(scroll_ofs), 32'd0);
                check("arst_fs", 32'(frame_start), 32'd0);
                model_reset();
                fb_age = -1;
            end
            if (rst_at >= 0 && j == rst_at + 4) rst = 1'b1;
            step();
        end
    endtask

    task automatic run(input logic [5:0] m, input int n);
        for (int f = 0; f < n; f++) frame(m, 10, m, 10, -1);
    endtask

    function automatic logic [5:0] rnd_mode();
        logic [5:0] m;
        m = 6'($urandom);
        if (m[5] && $urandom_range(0, 3) != 0) m[5] = 1'b0;
        return m;
    endfunction

    initial begin
        rst      = 1'b0;
        mode     = 6'd0;
        row_tick = 1'b0;
        row_bin  = 4'd0;
        model_reset();

        while (gcyc != 62) step();
        check("rst_ptn", 32'(ptn_idx), 32'd0);
        check("rst_blank", 32'(blank), 32'd1);
        check("rst_ofs", 32'(scroll_ofs), 32'd0);
        check("rst_fs", 32'(frame_start), 32'd0);
        rst = 1'b1;

        run(6'd0, 1);
        check("first_blank", 32'(blank), 32'd0);
        check("first_ptn", 32'(ptn_idx), 32'd0);

        run(6'b000011, 1);
        check("manual_3", 32'(ptn_idx), 32'd3);
        run(6'b000111, 1);
        check("manual_oob_blank", 32'(blank), 32'd1);
        check("manual_oob_ptn", 32'(ptn_idx), 32'd3);

        run(6'b001000, 28);
        check("auto_6", 32'(ptn_idx), 32'd6);
        run(6'b001000, 1);
        check("auto_wrap", 32'(ptn_idx), 32'd0);

        run(6'b010000, 31);
        check("scroll_15", 32'(scroll_ofs), 32'd15);
        run(6'b010000, 1);
        check("scroll_wrap", 32'(scroll_ofs), 32'd0);
        run(6'b010000, 2);
        check("scroll_1", 32'(scroll_ofs), 32'd1);
        run(6'b000000, 1);
        check("scroll_clear", 32'(scroll_ofs), 32'd0);

        run(6'b001000, 10);
        check("hold_pre", 32'(ptn_idx), 32'd2);
        run(6'b101000, 5);
        check("hold_frozen", 32'(ptn_idx), 32'd2);
        run(6'b001000, 2);
        check("hold_resume_2", 32'(ptn_idx), 32'd2);
        run(6'b001000, 1);
        check("hold_resume_3", 32'(ptn_idx), 32'd3);

        run(6'b000000, 1);
        run(6'b011000, 6);
        check("pre_rst_ptn", 32'(ptn_idx), 32'd1);
        check("pre_rst_ofs", 32'(scroll_ofs), 32'd3);
        frame(6'b011000, 10, 6'b011000, 10, 20);
        check("restart_ptn", 32'(ptn_idx), 32'd0);
        check("restart_blank", 32'(blank), 32'd0);
        check("restart_ofs", 32'(scroll_ofs), 32'd0);

        for (int f = 0; f < 60; f++) begin
            r1 = rnd_mode();
            r2 = rnd_mode();
            if ($urandom_range(0, 14) == 0)
                frame(r1, $urandom_range(0, 30), r2, $urandom_range(31, 55), $urandom_range(0, 40));
            else
                frame(r1, $urandom_range(0, 30), r2, $urandom_range(31, 55), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
